himax_frame_capture: RTL and testbench

- Capture stage between the Himax 4-bit parallel sensor port and the UART streaming path of the vision top level.
- Oversamples px_clk/px_fv/px_lv/pxd in the system clock domain and packs nibble pairs into bytes.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte stream to the UART transmitter.
- Captures exactly one full frame per start request and reports its row and column counts.

---
 rtl/himax_frame_capture.sv | 210 +++++++++++++++++++++
 tb/tb_himax_frame_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/himax_frame_capture.sv
// Himax 4-bit parallel sensor capture: oversamples the sensor port, packs nibble
// pairs into bytes, buffers them in a FIFO and measures one frame per start request.
module himax_frame_capture #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             px_clk,
  input  logic             px_fv,
  input  logic             px_lv,
  input  logic [3:0]       pxd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_rows,
  output logic [CNT_W-1:0] frame_cols,
  output logic             overflow,
  output logic             odd_nibble
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT_FV = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES:0]   pclk_sync_r;
  logic [SYNC_STAGES-1:0] fv_sync_r;
  logic [SYNC_STAGES-1:0] lv_sync_r;
  logic [3:0]             pxd_sync_r [SYNC_STAGES];

  state_t           state_r;
  logic             fv_q_r, lv_q_r;
  logic             phase_r;
  logic [3:0]       hi_r;
  logic [CNT_W-1:0] row_r, col_r, last_cols_r;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;

  logic             sample_s, fv_s, lv_s;
  logic [3:0]       pxd_s;
  logic             take_s, lv_fall_s, fv_rise_s, fv_fall_s;
  logic [CNT_W-1:0] row_inc_s;
  logic             push_s, pop_s, full_s, wr_en_s;

  // Synchronise every sensor input; px_clk gets one extra stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sync_r <= '0;
      fv_sync_r   <= '0;
      lv_sync_r   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) pxd_sync_r[i] <= 4'h0;
    end else begin
      pclk_sync_r[0] <= px_clk;
      fv_sync_r[0]   <= px_fv;
      lv_sync_r[0]   <= px_lv;
      pxd_sync_r[0]  <= pxd;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pclk_sync_r[i] <= pclk_sync_r[i-1];
        fv_sync_r[i]   <= fv_sync_r[i-1];
        lv_sync_r[i]   <= lv_sync_r[i-1];
        pxd_sync_r[i]  <= pxd_sync_r[i-1];
      end
      pclk_sync_r[SYNC_STAGES] <= pclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign sample_s  = pclk_sync_r[SYNC_STAGES-1] & ~pclk_sync_r[SYNC_STAGES];
  assign fv_s      = fv_sync_r[SYNC_STAGES-1];
  assign lv_s      = lv_sync_r[SYNC_STAGES-1];
  assign pxd_s     = pxd_sync_r[SYNC_STAGES-1];
  assign take_s    = sample_s & fv_s & lv_s;
  assign lv_fall_s = sample_s & lv_q_r & ~lv_s;
  assign fv_rise_s = sample_s & ~fv_q_r & fv_s;
  assign fv_fall_s = sample_s & fv_q_r & ~fv_s;
  assign row_inc_s = sat_inc(row_r);
  assign push_s    = (state_r == CAPTURE) & take_s & phase_r;

  // Capture FSM: arming, nibble pairing, line/frame bookkeeping and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      fv_q_r      <= 1'b0;
      lv_q_r      <= 1'b0;
      phase_r     <= 1'b0;
      hi_r        <= 4'h0;
      row_r       <= '0;
      col_r       <= '0;
      last_cols_r <= '0;
      frame_rows  <= '0;
      frame_cols  <= '0;
      odd_nibble  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample_s) begin
        fv_q_r <= fv_s;
        lv_q_r <= lv_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ARM;
            busy    <= 1'b1;
          end
        end
        ARM: begin
          if (!fv_s) state_r <= WAIT_FV;
        end
        WAIT_FV: begin
          if (fv_rise_s) begin
            state_r     <= CAPTURE;
            row_r       <= '0;
            col_r       <= '0;
            last_cols_r <= '0;
            phase_r     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (take_s) begin
            if (!phase_r) begin
              hi_r    <= pxd_s;
              phase_r <= 1'b1;
            end else begin
              phase_r <= 1'b0;
              col_r   <= sat_inc(col_r);
            end
          end
          // A line closing on the same sample as the frame is counted first
          if (lv_fall_s) begin
            row_r       <= row_inc_s;
            last_cols_r <= col_r;
            col_r       <= '0;
            phase_r     <= 1'b0;
            if (phase_r) odd_nibble <= 1'b1;
          end
          if (fv_fall_s) begin
            frame_rows <= lv_fall_s ? row_inc_s : row_r;
            frame_cols <= lv_fall_s ? col_r : last_cols_r;
            frame_done <= 1'b1;
            state_r    <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign pop_s   = out_valid & out_ready;
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign wr_en_s = push_s & (~full_s | pop_s);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // First-word-fall-through byte FIFO with sticky overflow on a dropped push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {hi_r, pxd_s};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_s & full_s & ~pop_s) overflow <= 1'b1;
      count_r   <= count_next_s;
      out_valid <= (count_next_s != CW'(0));
    end
  end

  assign out_data = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_himax_frame_capture.sv
// Bench for himax_frame_capture: table of frame scenarios plus hand-written
// sequences, bytes scored against a queue built from the sensor stream.
module tb_himax_frame_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        px_clk = 1'b0;
  logic        px_fv = 1'b0;
  logic        px_lv = 1'b0;
  logic [3:0]  pxd = 4'h0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, frame_done, overflow, odd_nibble;
  logic [15:0] frame_rows, frame_cols;

  himax_frame_capture #(.FIFO_DEPTH(16), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .px_clk(px_clk), .px_fv(px_fv),
    .px_lv(px_lv), .pxd(pxd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .frame_rows(frame_rows), .frame_cols(frame_cols), .overflow(overflow),
    .odd_nibble(odd_nibble)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_rx = 0;
  int         ready_mode = 0;   // 0 hold low, 1 always high, 2 random
  bit         done_prev = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         exp_odd = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pat[2048];

  typedef struct {
    int lines; int nib_first; int nib_rest; int ready;
    bit rnd; bit tight; bit drain; int keep;
    int exp_rows; int exp_cols;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Downstream: drive out_ready for the next edge, score any byte that edge will take
  always @(negedge clk) begin
    case (ready_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (frame_done) begin
      chk("done_width", 32'(done_prev), 32'd0);
      n_done++;
    end
    done_prev = frame_done;
    if (out_valid && out_ready && !rst) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL extra_byte: got %0h, expected no byte", out_data);
      end else begin
        chk("byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic align();
    @(posedge clk);
    #7;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic px(input logic fv, input logic lv, input logic [3:0] d, input bit pulse);
    px_clk = 1'b0; px_fv = fv; px_lv = lv; pxd = d;
    if (pulse) begin
      start = 1'b1; #10; start = 1'b0; #10;
    end else begin
      #20;
    end
    px_clk = 1'b1;
    #20;
  endtask

  // Sensor frame; the model queues each byte the DUT must deliver
  task automatic drive_frame(input int lines, input int nib_first, input int nib_rest,
                             input bit expect_bytes, input int keep_max, input int pulse_at,
                             input int abort_at, input bit tight, input bit rnd);
    int b = 0;
    int nib = 0;
    int pushed = 0;
    int n;
    logic [7:0] bv;
    for (int i = 0; i < 2048; i++) pat[i] = rnd ? 8'($urandom) : 8'(i % 176);
    align();
    repeat (2) px(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) px(1'b1, 1'b0, 4'h0, 1'b0);
    for (int l = 0; l < lines; l++) begin
      n = (l == 0) ? nib_first : nib_rest;
      for (int j = 0; j < n; j++) begin
        if (abort_at >= 0 && nib == abort_at) return;
        bv = pat[b + j / 2];
        if (j % 2 == 1 && expect_bytes) begin
          if (pushed < keep_max) exp_q.push_back(bv);
          else exp_ovf = 1'b1;
          pushed++;
        end
        px(1'b1, 1'b1, (j % 2 == 0) ? bv[7:4] : bv[3:0], nib == pulse_at);
        nib++;
      end
      b += n / 2;
      if (n % 2 == 1 && expect_bytes) exp_odd = 1'b1;
      if (!(tight && l == lines - 1)) repeat (2) px(1'b1, 1'b0, 4'h0, 1'b0);
    end
    repeat (3) px(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic drain_wait();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_frame(input string tag, input int d0, input int rows, input int cols);
    chk({tag, "_done"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_rows"}, 32'(frame_rows), 32'(rows));
    chk({tag, "_cols"}, 32'(frame_cols), 32'(cols));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_odd"}, 32'(odd_nibble), 32'(exp_odd));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_rows"}, 32'(frame_rows), 32'd0);
    chk({tag, "_cols"}, 32'(frame_cols), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_odd"}, 32'(odd_nibble), 32'd0);
  endtask

  initial begin
    int d0, rx0, rl, rn, k;
    rl = $urandom_range(1, 6);
    rn = 2 * $urandom_range(1, 40);
    //          lines nibF nibR rdy rnd tight drain keep     rows cols
    tbl[0] = '{30,  80,  80,  1,  1'b0, 1'b0, 1'b1, 1 << 30, 30, 40};
    tbl[1] = '{30,  80,  80,  2,  1'b0, 1'b0, 1'b0, 1 << 30, 30, 40};
    tbl[2] = '{30,  80,  80,  2,  1'b0, 1'b0, 1'b1, 1 << 30, 30, 40};
    tbl[3] = '{rl,  rn,  rn,  2,  1'b1, 1'b0, 1'b1, 1 << 30, rl, rn / 2};
    tbl[4] = '{30,  80,  80,  0,  1'b0, 1'b0, 1'b1, 16,      30, 40};
    tbl[5] = '{2,   81,  80,  1,  1'b0, 1'b1, 1'b1, 1 << 30, 2,  40};

    repeat (3) @(posedge clk);
    #1 chk_reset_state("rst0");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Start while a frame is in flight: that frame is skipped, the next is captured
    ready_mode = 1;
    d0 = n_done;
    drive_frame(8, 80, 80, 1'b0, 0, 200, -1, 1'b0, 1'b0);
    chk("skip_no_done", 32'(n_done - d0), 32'd0);
    chk("skip_busy", 32'(busy), 32'd1);
    drive_frame(30, 80, 80, 1'b1, 1 << 30, -1, -1, 1'b0, 1'b0);
    chk_frame("midarm", d0, 30, 40);
    drain_wait();

    for (int v = 0; v < 6; v++) begin
      ready_mode = tbl[v].ready;
      d0 = n_done;
      rx0 = n_rx;
      pulse_start();
      drive_frame(tbl[v].lines, tbl[v].nib_first, tbl[v].nib_rest, 1'b1, tbl[v].keep,
                  -1, -1, tbl[v].tight, tbl[v].rnd);
      chk_frame($sformatf("vec%0d", v), d0, tbl[v].exp_rows, tbl[v].exp_cols);
      if (tbl[v].ready == 0) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        ready_mode = 1;
      end
      if (tbl[v].drain) drain_wait();
      if (tbl[v].ready == 0) chk("hold_count", 32'(n_rx - rx0), 32'd16);
    end

    // Reset in the middle of a frame, then a clean capture from 0x00
    ready_mode = 1;
    pulse_start();
    drive_frame(30, 80, 80, 1'b1, 1 << 30, -1, 1000, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_bytes", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk_reset_state("rst_mid");
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_odd = 1'b0;
    #20;
    @(posedge clk); #1 rst = 1'b0;
    align();
    repeat (2) px(1'b1, 1'b0, 4'h0, 1'b0);
    repeat (2) px(1'b0, 1'b0, 4'h0, 1'b0);
    d0 = n_done;
    pulse_start();
    drive_frame(4, 80, 80, 1'b1, 1 << 30, -1, -1, 1'b0, 1'b0);
    chk_frame("post_rst", d0, 4, 40);
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
